// File: rtl/dmem_uart_bridge.sv
// Data-side memory slave for the pipelined RV32 core: a word-addressed RAM plus a
// memory-mapped, transmit-only 8N1 UART fed by a small TX FIFO.
module dmem_uart_bridge #(
   parameter int RAM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 4,
   parameter int CLK_DIV    = 434
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wr_data_i,
   input  logic        mem_wr_sig_i,
   output logic [31:0] mem_rd_data_o,
   output logic        uart_tx_o,
   output logic        tx_busy_o
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [31:0] TXDATA_ADDR  = 32'h8000_0000;
   localparam logic [31:0] STATUS_ADDR  = 32'h8000_0004;
   localparam logic [31:0] DIVISOR_ADDR = 32'h8000_0008;
   localparam logic [PW:0] FULL_COUNT   = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [31:0]   ram [RAM_WORDS];
   logic [7:0]    fifo [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          overflow;
   logic [15:0]   divisor;

   state_t        state, state_n;
   logic [15:0]   cnt, cnt_n;
   logic [15:0]   bit_len, bit_len_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    shift, shift_n;
   logic          tx_n;
   logic          pop;
   logic          load;

   logic          ram_sel;
   logic [AW-1:0] word;
   logic          fifo_empty;
   logic          fifo_full;
   logic          push_req;
   logic          push;
   logic          status_wr;
   logic          div_wr;

   assign ram_sel    = (mem_addr_i[31:AW+2] == '0);
   assign word       = mem_addr_i[AW+1:2];
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_COUNT);
   assign push_req   = mem_wr_sig_i && (mem_addr_i == TXDATA_ADDR);
   assign push       = push_req && !fifo_full;
   assign status_wr  = mem_wr_sig_i && (mem_addr_i == STATUS_ADDR);
   assign div_wr     = mem_wr_sig_i && (mem_addr_i == DIVISOR_ADDR);

   always_ff @(posedge clk) begin
      if (mem_wr_sig_i && ram_sel)
         ram[word] <= mem_wr_data_i;
   end

   always_comb begin
      mem_rd_data_o = '0;
      if (ram_sel)
         mem_rd_data_o = ram[word];
      else if (mem_addr_i == STATUS_ADDR)
         mem_rd_data_o = {28'b0, overflow, fifo_empty, fifo_full, tx_busy_o};
      else if (mem_addr_i == DIVISOR_ADDR)
         mem_rd_data_o = {16'b0, divisor};
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo[wr_ptr] <= mem_wr_data_i[7:0];
   end

   // Full is judged on the pre-edge count, so a push into a full FIFO is lost
   // even when the UART frees a slot on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
         if (push_req && fifo_full)
            overflow <= 1'b1;
         else if (status_wr && mem_wr_data_i[3])
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         divisor <= 16'(CLK_DIV);
      else if (div_wr)
         divisor <= (mem_wr_data_i[15:0] == 16'd0) ? 16'd1 : mem_wr_data_i[15:0];
   end

   // Every bit period ends when cnt reaches 1; bit_len holds the divisor
   // captured at frame start so mid-frame divisor writes wait a frame.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_len_n = bit_len;
      idx_n     = idx;
      shift_n   = shift;
      tx_n      = uart_tx_o;
      load      = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifo_empty)
               load = 1'b1;
         end
         START: begin
            if (cnt <= 16'd1) begin
               cnt_n   = bit_len;
               idx_n   = 3'd0;
               tx_n    = shift[0];
               state_n = DATA;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         DATA: begin
            if (cnt <= 16'd1) begin
               cnt_n = bit_len;
               if (idx == 3'd7) begin
                  tx_n    = 1'b1;
                  state_n = STOP;
               end else begin
                  idx_n   = idx + 3'd1;
                  shift_n = {1'b0, shift[7:1]};
                  tx_n    = shift[1];
               end
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         STOP: begin
            if (cnt <= 16'd1) begin
               if (!fifo_empty) begin
                  load = 1'b1;
               end else begin
                  tx_n    = 1'b1;
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         default: state_n = IDLE;
      endcase
      pop = load;
      if (load) begin
         shift_n   = fifo[rd_ptr];
         bit_len_n = divisor;
         cnt_n     = divisor;
         tx_n      = 1'b0;
         state_n   = START;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_len   <= 16'(CLK_DIV);
         idx       <= '0;
         shift     <= '0;
         uart_tx_o <= 1'b1;
         tx_busy_o <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_len   <= bit_len_n;
         idx       <= idx_n;
         shift     <= shift_n;
         uart_tx_o <= tx_n;
         tx_busy_o <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_dmem_uart_bridge.sv
// Self-checking bench for dmem_uart_bridge: directed platform scenarios plus randomized
// RAM traffic and UART byte streams compared against a frame-level serial model.
`timescale 1ns/1ps
module tb_dmem_uart_bridge;

   localparam int HIST = 16384;
   localparam logic [31:0] TXDATA  = 32'h8000_0000;
   localparam logic [31:0] STATUS  = 32'h8000_0004;
   localparam logic [31:0] DIVISOR = 32'h8000_0008;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wr;
   logic [31:0] rdata;
   logic        tx;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_edge = 0;
   logic tx_hist [HIST];
   logic busy_hist [HIST];
   logic [31:0] ram_model [int];
   int keys[$];
   logic [7:0] sent[$];

   dmem_uart_bridge #(.RAM_WORDS(1024), .FIFO_DEPTH(4), .CLK_DIV(434)) dut (
      .clk(clk), .reset_n(reset_n), .mem_addr_i(addr), .mem_wr_data_i(wdata),
      .mem_wr_sig_i(wr), .mem_rd_data_o(rdata), .uart_tx_o(tx), .tx_busy_o(busy)
   );

   always #5 clk = ~clk;

   // Serial line history, sampled 1 ns after each rising edge and indexed by edge number.
   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc < HIST) begin
         tx_hist[cyc]   = tx;
         busy_hist[cyc] = busy;
      end
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] timeout");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apply_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      wr    = 1'b1;
      @(posedge clk);
      #1;
      wr        = 1'b0;
      last_edge = cyc;
   endtask

   task automatic read_word(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a;
      wr   = 1'b0;
      #1;
      d = rdata;
   endtask

   task automatic ram_write(input logic [31:0] a, input logic [31:0] d);
      int w;
      apply_write(a, d);
      w = int'(a[11:2]);
      if (!ram_model.exists(w))
         keys.push_back(w);
      ram_model[w] = d;
   endtask

   // Expected line: frames of 10*div cycles back to back from edge k+1,
   // each a low start bit, eight data bits LSB first, and a high stop bit.
   task automatic check_stream(input string tag, input int k, input int div);
      int frame_len;
      int total;
      int bad;
      frame_len = 10 * div;
      total     = frame_len * sent.size();
      bad       = 0;
      while (cyc < k + total + 2)
         @(posedge clk);
      #2;
      for (int n = 1; n <= total; n++) begin
         int f;
         int b;
         logic [7:0] by;
         logic e;
         f  = (n - 1) / frame_len;
         b  = ((n - 1) % frame_len) / div;
         by = sent[f];
         if (b == 0)
            e = 1'b0;
         else if (b <= 8)
            e = by[b-1];
         else
            e = 1'b1;
         if (tx_hist[k+n] !== e || busy_hist[k+n] !== 1'b1)
            bad++;
      end
      check_output({tag, " wave_errors"}, 32'(bad), 32'd0);
      check_output({tag, " idle_tx"}, {31'b0, tx_hist[k+total+1]}, 32'd1);
      check_output({tag, " busy_fall"}, {31'b0, busy_hist[k+total+1]}, 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] a;
      int k;
      int w;
      int div;
      int n;
      logic [7:0] by;

      addr    = '0;
      wdata   = '0;
      wr      = 1'b0;
      reset_n = 1'b0;

      // Reset state, with reads live while reset is held
      #23;
      check_output("reset tx", {31'b0, tx}, 32'd1);
      check_output("reset busy", {31'b0, busy}, 32'd0);
      read_word(STATUS, d);
      check_output("reset status", d, 32'h4);
      read_word(DIVISOR, d);
      check_output("reset divisor", d, 32'd434);
      @(negedge clk);
      reset_n = 1'b1;

      // RAM write/read with ignored byte offset
      ram_write(32'h0000_0014, 32'h0BAD_F00D);
      ram_write(32'h0000_0010, 32'hDEAD_BEEF);
      read_word(32'h0000_0010, d);
      check_output("ram 0x10", d, 32'hDEAD_BEEF);
      read_word(32'h0000_0013, d);
      check_output("ram 0x13", d, 32'hDEAD_BEEF);
      read_word(32'h0000_0014, d);
      check_output("ram 0x14", d, 32'h0BAD_F00D);

      // Decode: out-of-range and unmapped writes are ignored
      ram_write(32'h0000_0000, 32'hCAFE_F00D);
      apply_write(32'h0000_1000, 32'h1234);
      read_word(32'h0000_1000, d);
      check_output("unmapped 0x1000", d, 32'h0);
      read_word(32'h0000_0000, d);
      check_output("no alias word0", d, 32'hCAFE_F00D);
      apply_write(32'h8000_000C, 32'h1234);
      read_word(32'h8000_000C, d);
      check_output("unmapped 0x8000000C", d, 32'h0);
      read_word(TXDATA, d);
      check_output("txdata read", d, 32'h0);
      apply_write(DIVISOR, 32'h0);
      read_word(DIVISOR, d);
      check_output("divisor zero->1", d, 32'd1);
      apply_write(DIVISOR, 32'hABCD_1234);
      read_word(DIVISOR, d);
      check_output("divisor upper bits", d, 32'h1234);

      // Single byte at divisor 4
      apply_write(DIVISOR, 32'd4);
      sent.delete();
      sent.push_back(8'h55);
      apply_write(TXDATA, 32'h55);
      k = last_edge;
      check_output("single tx before start", {31'b0, tx}, 32'd1);
      @(posedge clk);
      #1;
      check_output("single tx start low", {31'b0, tx}, 32'd0);
      check_output("single busy", {31'b0, busy}, 32'd1);
      check_stream("single", k, 4);

      // Back-to-back frames at divisor 2
      apply_write(DIVISOR, 32'd2);
      sent.delete();
      sent.push_back(8'h01);
      sent.push_back(8'h80);
      apply_write(TXDATA, 32'h01);
      k = last_edge;
      apply_write(TXDATA, 32'h80);
      read_word(STATUS, d);
      check_output("b2b status frame1", d, 32'h1);
      while (cyc < k + 22)
         @(posedge clk);
      read_word(STATUS, d);
      check_output("b2b status frame2", d, 32'h5);
      check_stream("b2b", k, 2);

      // Randomized RAM traffic including out-of-range writes
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            a = (32'($urandom) & 32'h7FFF_FFFC) | 32'h0000_1000;
            apply_write(a, $urandom);
            read_word(a, d);
            check_output("rand unmapped", d, 32'h0);
            w = int'(a[11:2]);
            if (ram_model.exists(w)) begin
               read_word({20'b0, a[11:2], 2'b00}, d);
               check_output("rand alias", d, ram_model[w]);
            end
         end else if ($urandom_range(0, 1) == 0) begin
            a = 32'($urandom_range(0, 1023) * 4 + $urandom_range(0, 3));
            ram_write(a, $urandom);
         end else begin
            w = keys[$urandom_range(0, keys.size() - 1)];
            a = 32'(w * 4 + $urandom_range(0, 3));
            read_word(a, d);
            check_output("rand ram read", d, ram_model[w]);
         end
      end

      // Randomized UART streams
      for (int i = 0; i < 3; i++) begin
         div = $urandom_range(1, 5);
         n   = $urandom_range(1, 5);
         apply_write(DIVISOR, 32'(div));
         sent.delete();
         for (int j = 0; j < n; j++) begin
            by = 8'($urandom);
            sent.push_back(by);
            apply_write(TXDATA, {24'b0, by});
            if (j == 0)
               k = last_edge;
         end
         check_stream("rand stream", k, div);
         read_word(STATUS, d);
         check_output("rand stream status", d, 32'h4);
      end

      // Overflow, then reset in the middle of a frame
      ram_write(32'h0000_0020, 32'h1357_2468);
      apply_write(DIVISOR, 32'd100);
      apply_write(TXDATA, 32'h37);
      k = last_edge;
      for (int j = 1; j < 6; j++)
         apply_write(TXDATA, 32'(8'hA0 + j));
      read_word(STATUS, d);
      check_output("overflow status", d, 32'hB);
      apply_write(STATUS, 32'h8);
      read_word(STATUS, d);
      check_output("overflow cleared", d, 32'h3);
      while (cyc < k + 450)
         @(posedge clk);
      #2;
      check_output("data bit3 before reset", {31'b0, tx}, 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check_output("async reset tx", {31'b0, tx}, 32'd1);
      check_output("async reset busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      read_word(STATUS, d);
      check_output("post reset status", d, 32'h4);
      read_word(32'h0000_0020, d);
      check_output("ram kept over reset", d, 32'h1357_2468);
      read_word(DIVISOR, d);
      check_output("post reset divisor", d, 32'd434);
      repeat (5) @(posedge clk);
      #2;
      check_output("fifo discarded tx", {31'b0, tx}, 32'd1);
      check_output("fifo discarded busy", {31'b0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
